// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters and a
// registered output stage (sync, blanking, coordinates, line/frame strobes).
module vga_timing_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          lineStart,
  output logic          frameStart
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic          HP       = (H_POL != 0);
  localparam logic          VP       = (V_POL != 0);

  logic [DW-1:0] div;
  logic [CW-1:0] hc, vc;
  logic          tick, in_hs, in_vs;

  assign tick  = EN && (div == DIV_LAST);
  assign in_hs = (hc >= H_SS) && (hc < H_SE);
  assign in_vs = (vc >= V_SS) && (vc < V_SE);

  // EN low is treated exactly like reset so re-enabling restarts at (0,0).
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      div        <= '0;
      hc         <= '0;
      vc         <= '0;
      X          <= '0;
      Y          <= '0;
      bright     <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      hSync      <= ~HP;
      vSync      <= ~VP;
    end else if (!EN) begin
      div        <= '0;
      hc         <= '0;
      vc         <= '0;
      X          <= '0;
      Y          <= '0;
      bright     <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      hSync      <= ~HP;
      vSync      <= ~VP;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      if (tick) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
        // Outputs reflect the pre-tick position: one pixel of latency.
        X          <= hc;
        Y          <= vc;
        bright     <= (hc < H_ACT) && (vc < V_ACT);
        hSync      <= in_hs ? HP : ~HP;
        vSync      <= in_vs ? VP : ~VP;
        lineStart  <= (hc == '0);
        frameStart <= (hc == '0) && (vc == '0);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries share CLR/EN and are compared
// every cycle against a closed-form position model driven by enabled-cycle count.
module tb_vga_timing_gen;
  logic CLK = 1'b0, CLR = 1'b0, EN = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0] x, y;
    logic b, hs, vs, ls, fs;
  } st_t;

  localparam int DV[3] = '{4, 1, 2};
  localparam int HA[3] = '{640, 640, 20};
  localparam int HF[3] = '{16, 16, 2};
  localparam int HS[3] = '{96, 96, 3};
  localparam int HB[3] = '{48, 48, 4};
  localparam int VA[3] = '{480, 480, 10};
  localparam int VF[3] = '{10, 10, 2};
  localparam int VS[3] = '{2, 2, 2};
  localparam int VB[3] = '{33, 33, 3};
  localparam int HP[3] = '{0, 0, 1};
  localparam int VP[3] = '{0, 0, 1};

  logic [9:0] xo[3], yo[3];
  logic hso[3], vso[3], bo[3], lso[3], fso[3];

  vga_timing_gen #(.DIV(4)) u0 (.CLK(CLK), .CLR(CLR), .EN(EN), .hSync(hso[0]), .vSync(vso[0]),
    .bright(bo[0]), .X(xo[0]), .Y(yo[0]), .lineStart(lso[0]), .frameStart(fso[0]));
  vga_timing_gen #(.DIV(1)) u1 (.CLK(CLK), .CLR(CLR), .EN(EN), .hSync(hso[1]), .vSync(vso[1]),
    .bright(bo[1]), .X(xo[1]), .Y(yo[1]), .lineStart(lso[1]), .frameStart(fso[1]));
  vga_timing_gen #(.DIV(2), .H_ACTIVE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .H_POL(1), .V_POL(1), .CW(10)) u2 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .hSync(hso[2]), .vSync(vso[2]),
    .bright(bo[2]), .X(xo[2]), .Y(yo[2]), .lineStart(lso[2]), .frameStart(fso[2]));

  int c, tests, fails;

  // Count of consecutive enabled clock edges since the last reset/disable.
  always @(posedge CLK or negedge CLR)
    if (!CLR) c <= 0;
    else if (EN) c <= c + 1;
    else c <= 0;

  // Position after cc enabled edges: ticks land on every DIV-th edge and
  // each tick shows the raster position counted from frame start.
  function automatic st_t model(int k, int cc);
    st_t e;
    int ht, vt, t, p, xx, yy;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    e.x = '0; e.y = '0; e.b = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    e.hs = (HP[k] == 0);
    e.vs = (VP[k] == 0);
    t = cc / DV[k];
    if (t > 0) begin
      p  = (t - 1) % (ht * vt);
      xx = p % ht;
      yy = p / ht;
      e.x  = 10'(xx);
      e.y  = 10'(yy);
      e.b  = (xx < HA[k]) && (yy < VA[k]);
      e.hs = (xx >= HA[k] + HF[k] && xx < HA[k] + HF[k] + HS[k]) ? (HP[k] != 0) : (HP[k] == 0);
      e.vs = (yy >= VA[k] + VF[k] && yy < VA[k] + VF[k] + VS[k]) ? (VP[k] != 0) : (VP[k] == 0);
      e.ls = (cc % DV[k] == 0) && (xx == 0);
      e.fs = e.ls && (yy == 0);
    end
    return e;
  endfunction

  function automatic st_t obs(int k);
    st_t o;
    o.x = xo[k]; o.y = yo[k]; o.b = bo[k];
    o.hs = hso[k]; o.vs = vso[k]; o.ls = lso[k]; o.fs = fso[k];
    return o;
  endfunction

  task automatic test_reset();
    st_t o, e;
    CLR = 1'b0; EN = 1'b1;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      o = obs(k); e = model(k, 0);
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset inst%0d got=%h exp=%h", k, o, e); end
    end
  endtask

  task automatic test_first_tick();
    st_t o, e;
    CLR = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge CLK);
      tests++;
      if (fso[0] !== (n == 4)) begin
        fails++; $display("FAIL first_fs cyc=%0d got=%b exp=%b", n, fso[0], (n == 4));
      end
      for (int k = 0; k < 3; k++) begin
        o = obs(k); e = model(k, c);
        tests++;
        if (o !== e) begin fails++; $display("FAIL first inst%0d c=%0d got=%h exp=%h", k, c, o, e); end
      end
    end
  endtask

  task automatic test_line_div1();
    st_t o, e;
    int hs_low, br, ls_n, guard;
    guard = 0;
    while (lso[1] !== 1'b1 && guard < 1000) begin @(negedge CLK); guard++; end
    tests++;
    if (guard >= 1000) begin fails++; $display("FAIL line_start_timeout got=%0d exp<1000", guard); end
    hs_low = 0; br = 0; ls_n = 0;
    for (int n = 0; n < 800; n++) begin
      if (hso[1] === 1'b0) hs_low++;
      if (bo[1] === 1'b1) br++;
      if (lso[1] === 1'b1) ls_n++;
      for (int k = 0; k < 3; k++) begin
        o = obs(k); e = model(k, c);
        tests++;
        if (o !== e) begin fails++; $display("FAIL line inst%0d c=%0d got=%h exp=%h", k, c, o, e); end
      end
      @(negedge CLK);
    end
    tests++;
    if (hs_low != 96) begin fails++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
    tests++;
    if (br != 640) begin fails++; $display("FAIL bright_width got=%0d exp=640", br); end
    tests++;
    if (ls_n != 1 || lso[1] !== 1'b1) begin
      fails++; $display("FAIL line_period got=%0d/%b exp=1/1", ls_n, lso[1]);
    end
  endtask

  task automatic test_frame_small();
    st_t o, e;
    int first, second, guard;
    first = -1; second = -1; guard = 0;
    while (second < 0 && guard < 2500) begin
      @(negedge CLK); guard++;
      if (fso[2] === 1'b1) begin
        if (first < 0) first = guard; else second = guard;
      end
      for (int k = 0; k < 3; k++) begin
        o = obs(k); e = model(k, c);
        tests++;
        if (o !== e) begin fails++; $display("FAIL frame inst%0d c=%0d got=%h exp=%h", k, c, o, e); end
      end
    end
    tests++;
    if (second - first != 29 * 17 * 2) begin
      fails++; $display("FAIL frame_period got=%0d exp=%0d", second - first, 29 * 17 * 2);
    end
  endtask

  task automatic test_en_drop();
    st_t o, e;
    repeat ($urandom_range(50, 400)) @(negedge CLK);
    EN = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n == 10) EN = 1'b1;
      @(negedge CLK);
      if (n == 13) begin
        tests++;
        if (fso[0] !== 1'b1) begin fails++; $display("FAIL restart_fs got=%b exp=1", fso[0]); end
      end
      for (int k = 0; k < 3; k++) begin
        o = obs(k); e = model(k, c);
        tests++;
        if (o !== e) begin fails++; $display("FAIL en_drop inst%0d n=%0d got=%h exp=%h", k, n, o, e); end
      end
    end
  endtask

  task automatic test_async_clr();
    st_t o, e;
    int guard;
    guard = 0;
    while (xo[1] !== 10'd700 && guard < 1000) begin @(negedge CLK); guard++; end
    tests++;
    if (hso[1] !== 1'b0 || guard >= 1000) begin
      fails++; $display("FAIL pre_clr_hsync got=%b exp=0 wait=%0d", hso[1], guard);
    end
    CLR = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k); e = model(k, 0);
      tests++;
      if (o !== e) begin fails++; $display("FAIL async_clr inst%0d got=%h exp=%h", k, o, e); end
    end
    @(negedge CLK);
    CLR = 1'b1;
  endtask

  task automatic test_random();
    st_t o, e;
    int act, len;
    for (int s = 0; s < 30; s++) begin
      act = $urandom_range(0, 9);
      if (act == 9) begin
        CLR = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          o = obs(k); e = model(k, 0);
          tests++;
          if (o !== e) begin fails++; $display("FAIL rnd_clr inst%0d got=%h exp=%h", k, o, e); end
        end
        @(negedge CLK);
        CLR = 1'b1;
      end
      EN  = (act < 7);
      len = (act < 7) ? $urandom_range(1, 400) : $urandom_range(1, 12);
      repeat (len) begin
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
          o = obs(k); e = model(k, c);
          tests++;
          if (o !== e) begin fails++; $display("FAIL rnd inst%0d c=%0d got=%h exp=%h", k, c, o, e); end
        end
      end
    end
    EN = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_first_tick();
    test_line_div1();
    test_frame_small();
    test_en_drop();
    test_async_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
